// File: rtl/display_share_arbiter_if.sv
// display_share_arbiter_if: requester inputs and granted-word outputs of the display arbiter
interface display_share_arbiter_if #(parameter int N = 4);
  logic tick;
  logic next;
  logic freeze;
  logic [N-1:0] req;
  logic [16*N-1:0] data;
  logic [N-1:0] gnt;
  logic [2:0] gnt_id;
  logic valid;
  logic [15:0] q;
  modport master(output tick, next, freeze, req, data, input gnt, gnt_id, valid, q);
  modport slave(input tick, next, freeze, req, data, output gnt, gnt_id, valid, q);
endinterface

// File: rtl/display_share_arbiter.sv
// display_share_arbiter: round-robin share of the seven-segment word between N requesters,
// advancing after DWELL ticks, on a manual next pulse, or when the holder drops its request.
module display_share_arbiter #(
  parameter int N = 4,
  parameter int DWELL = 8
) (
  input logic clk,
  input logic rst,
  display_share_arbiter_if.slave bus
);
  typedef enum logic {IDLE, SHOW} state_t;
  state_t state, state_n;
  logic [N-1:0] gnt_n;
  logic [2:0] gnt_id_n, last, last_n, pick;
  logic valid_n, found, run, rearb;
  logic [15:0] q_n;
  logic [7:0] dwell, dwell_n;
  logic [7:0] req_x;
  logic [127:0] data_x;
  assign req_x = 8'(bus.req);
  assign data_x = 128'(bus.data);
  // Lowest offset after the last grant wins; the holder itself is reached last.
  always_comb begin
    found = 1'b0;
    pick = last;
    for (int k = N; k >= 1; k--)
      if (req_x[3'((int'(last) + k) % N)]) begin
        found = 1'b1;
        pick = 3'((int'(last) + k) % N);
      end
  end
  assign run = bus.tick & ~bus.freeze;
  assign rearb = (run && dwell == 8'(DWELL - 1)) || (bus.next && !bus.freeze) || !req_x[bus.gnt_id];
  always_comb begin
    state_n = state;
    gnt_n = bus.gnt;
    gnt_id_n = bus.gnt_id;
    valid_n = bus.valid;
    q_n = bus.q;
    dwell_n = dwell;
    last_n = last;
    if (state == SHOW) begin
      q_n = data_x[{bus.gnt_id, 4'b0000} +: 16];
      dwell_n = run ? dwell + 8'd1 : dwell;
    end
    if ((state == IDLE || rearb) && found) begin
      state_n = SHOW;
      gnt_n = N'(1) << pick;
      gnt_id_n = pick;
      valid_n = 1'b1;
      q_n = data_x[{pick, 4'b0000} +: 16];
      dwell_n = 8'd0;
      last_n = pick;
    end else if (state == SHOW && rearb) begin
      state_n = IDLE;
      gnt_n = '0;
      valid_n = 1'b0;
      q_n = bus.q;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.gnt_id <= 3'd0;
      bus.valid <= 1'b0;
      bus.q <= 16'h0000;
      dwell <= 8'd0;
      last <= 3'(N - 1);
    end else begin
      state <= state_n;
      bus.gnt <= gnt_n;
      bus.gnt_id <= gnt_id_n;
      bus.valid <= valid_n;
      bus.q <= q_n;
      dwell <= dwell_n;
      last <= last_n;
    end
  end
endmodule

// File: tb/tb_display_share_arbiter.sv
// tb_display_share_arbiter: directed scenarios plus random traffic against a queue-free
// round-robin reference model, compared on every falling edge.
module tb_display_share_arbiter;
  localparam int N = 4;
  localparam int DWELL = 8;
  logic clk = 0;
  logic rst = 0;
  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;
  display_share_arbiter_if #(.N(N)) bus();
  display_share_arbiter #(.N(N), .DWELL(DWELL)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int m_last, m_dw, m_id, p;
  bit m_v, adv;
  logic [15:0] m_q;
  function automatic int rr_pick(logic [N-1:0] r, int from);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction
  function automatic logic [15:0] word(logic [16*N-1:0] d, int i);
    return d[16*i +: 16];
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_v = 0; m_id = 0; m_q = 16'h0; m_dw = 0; m_last = N - 1;
    end else if (!m_v) begin
      p = rr_pick(bus.req, m_last);
      if (p >= 0) begin
        m_v = 1; m_id = p; m_last = p; m_dw = 0; m_q = word(bus.data, p);
      end
    end else begin
      adv = (bus.tick && !bus.freeze && m_dw == DWELL - 1) || (bus.next && !bus.freeze) || !bus.req[m_id];
      if (bus.tick && !bus.freeze) m_dw++;
      if (!adv) m_q = word(bus.data, m_id);
      else begin
        p = rr_pick(bus.req, m_last);
        if (p < 0) m_v = 0;
        else begin
          m_id = p; m_last = p; m_dw = 0; m_q = word(bus.data, p);
        end
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("gnt", 32'(bus.gnt), m_v ? 32'(1) << m_id : 32'd0);
    chk("gnt_id", 32'(bus.gnt_id), 32'(m_id));
    chk("valid", 32'(bus.valid), 32'(m_v));
    chk("q", 32'(bus.q), 32'(m_q));
  end
  task automatic step(bit t, bit n);
    bus.tick = t;
    bus.next = n;
    @(posedge clk);
    #2;
    bus.tick = 0;
    bus.next = 0;
  endtask
  task automatic ticks(int k);
    repeat (k) step(1, 0);
  endtask
  initial begin
    bus.tick = 0; bus.next = 0; bus.freeze = 0; bus.req = 4'b1111;
    bus.data = {16'h4444, 16'h2222, 16'h3333, 16'h1111};
    repeat (2) @(posedge clk);
    #2;
    chk_on = 1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_q", 32'(bus.q), 32'h0);
    rst = 1;
    step(0, 0);
    chk("first_gnt", 32'(bus.gnt), 32'b0001);
    chk("first_q", 32'(bus.q), 32'h1111);
    bus.req = 4'b0101;
    ticks(8);
    chk("dwell_gnt", 32'(bus.gnt), 32'b0100);
    chk("dwell_q", 32'(bus.q), 32'h2222);
    ticks(7);
    chk("dwell_hold", 32'(bus.gnt), 32'b0100);
    ticks(1);
    chk("dwell_back", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b1011;
    ticks(3);
    step(0, 1);
    chk("next_gnt", 32'(bus.gnt), 32'b0010);
    chk("next_q", 32'(bus.q), 32'h3333);
    ticks(7);
    chk("next_hold", 32'(bus.gnt), 32'b0010);
    ticks(1);
    chk("next_dwell", 32'(bus.gnt), 32'b1000);
    bus.req = 4'b0010;
    step(0, 0);
    chk("drop_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = 4'b0000;
    step(0, 0);
    chk("idle_valid", 32'(bus.valid), 32'h0);
    chk("idle_gnt", 32'(bus.gnt), 32'h0);
    chk("idle_q", 32'(bus.q), 32'h3333);
    step(1, 1);
    chk("idle_pulse", 32'(bus.valid), 32'h0);
    bus.req = 4'b0101;
    step(0, 0);
    chk("frz_start", 32'(bus.gnt), 32'b0100);
    bus.freeze = 1;
    for (int i = 0; i < 20; i++) step(1, i % 7 == 3);
    chk("frz_hold", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0001;
    step(0, 0);
    chk("frz_drop", 32'(bus.gnt), 32'b0001);
    chk("frz_drop_q", 32'(bus.q), 32'h1111);
    bus.freeze = 0;
    bus.req = 4'b1100;
    step(0, 0);
    chk("col_start", 32'(bus.gnt), 32'b0100);
    ticks(7);
    chk("col_pre", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b1000;
    step(1, 1);
    chk("col_gnt", 32'(bus.gnt), 32'b1000);
    chk("col_q", 32'(bus.q), 32'h4444);
    rst = 0;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'h0);
    chk("arst_valid", 32'(bus.valid), 32'h0);
    chk("arst_q", 32'(bus.q), 32'h0);
    step(0, 0);
    bus.req = 4'b1111;
    rst = 1;
    step(0, 0);
    chk("arst_restart", 32'(bus.gnt), 32'b0001);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) bus.req = 4'($urandom);
      bus.data = {$urandom, $urandom};
      if ($urandom_range(19) == 0) bus.freeze = !bus.freeze;
      rst = ($urandom_range(399) != 0);
      step($urandom_range(2) == 0, $urandom_range(15) == 0);
    end
    rst = 1;
    step(0, 0);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
